spi_write_arbiter: RTL and testbench

SPI_WRITE_ARBITER -- requirements
Module: spi_write_arbiter

---
 rtl/spi_write_arbiter.sv | 145 ++++++++++++++
 tb/tb_spi_write_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_write_arbiter.sv
// spi_write_arbiter: round-robin arbiter that funnels four SPI write slaves
// into one shadow register bank, one write per IDLE/WRITE/RELEASE pass.
// Ports:
//   clk, rst      : system clock, async active-high reset
//   wr, din       : per-slave write request level and data (slave i at din[i*Nbit +: Nbit])
//   clr_err       : synchronous clear of tmo_err
//   wtreq         : per-slave wait request (0 = write accepted)
//   we/wadr/wdata : one-cycle write strobe, slave index and data
//   bank          : shadow register bank (register i at bank[i*Nbit +: Nbit])
//   busy, tmo_err : FSM not idle, sticky RELEASE timeout flag
module spi_write_arbiter #(
    parameter int              Nbit    = 8,
    parameter logic [Nbit-1:0] RST_VAL = {Nbit{1'b1}},
    parameter int              TMO     = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        wr,
    input  logic [4*Nbit-1:0] din,
    input  logic              clr_err,
    output logic [3:0]        wtreq,
    output logic              we,
    output logic [1:0]        wadr,
    output logic [Nbit-1:0]   wdata,
    output logic [4*Nbit-1:0] bank,
    output logic              busy,
    output logic              tmo_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        last_q, last_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [3:0]        wtreq_q, wtreq_d;
    logic [1:0]        wadr_q, wadr_d;
    logic [Nbit-1:0]   wdata_q, wdata_d;
    logic [4*Nbit-1:0] bank_q, bank_d;
    logic              tmo_err_q, tmo_err_d;

    logic [1:0]        grant;
    logic              found;
    logic              tmo_hit;

    // Round-robin search starting just after the last granted slave.
    always_comb begin
        grant = last_q;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!found && wr[2'(32'(last_q) + k)]) begin
                grant = 2'(32'(last_q) + k);
                found = 1'b1;
            end
        end
    end

    // Counter holds the number of completed held RELEASE cycles, so the
    // TMO-th held cycle is the one that times out.
    assign tmo_hit = (state_q == RELEASE) && wr[last_q]
                   && (cnt_q == 8'(TMO - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (|wr) state_d = WRITE;
            WRITE:   state_d = RELEASE;
            RELEASE: if (!wr[last_q] || tmo_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        we_d      = 1'b0;
        wtreq_d   = 4'hF;
        wadr_d    = wadr_q;
        wdata_d   = wdata_q;
        bank_d    = bank_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        tmo_err_d = tmo_err_q;
        unique case (state_q)
            IDLE: begin
                if (|wr) begin
                    we_d           = 1'b1;
                    wtreq_d[grant] = 1'b0;
                    wadr_d         = grant;
                    last_d         = grant;
                    wdata_d        = din[32'(grant)*Nbit +: Nbit];
                    bank_d[32'(grant)*Nbit +: Nbit] =
                        din[32'(grant)*Nbit +: Nbit];
                end
            end
            WRITE:   cnt_d = 8'd0;
            RELEASE: if (wr[last_q]) cnt_d = cnt_q + 8'd1;
            default: ;
        endcase
        // A timeout wins over a simultaneous clear.
        if (tmo_hit)      tmo_err_d = 1'b1;
        else if (clr_err) tmo_err_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q      <= 1'b0;
            wtreq_q   <= 4'hF;
            wadr_q    <= 2'd0;
            wdata_q   <= '0;
            bank_q    <= {4{RST_VAL}};
            last_q    <= 2'd3;
            cnt_q     <= 8'd0;
            tmo_err_q <= 1'b0;
        end else begin
            we_q      <= we_d;
            wtreq_q   <= wtreq_d;
            wadr_q    <= wadr_d;
            wdata_q   <= wdata_d;
            bank_q    <= bank_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign we      = we_q;
    assign wtreq   = wtreq_q;
    assign wadr    = wadr_q;
    assign wdata   = wdata_q;
    assign bank    = bank_q;
    assign busy    = (state_q != IDLE);
    assign tmo_err = tmo_err_q;

endmodule

// File: tb/tb_spi_write_arbiter.sv
// tb_spi_write_arbiter: directed table-driven checks plus hand sequences
// for round-robin order, timeout, held-off requests and reset abort.
module tb_spi_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  wr;
    logic [31:0] din;
    logic        clr_err;
    logic [3:0]  wtreq;
    logic        we;
    logic [1:0]  wadr;
    logic [7:0]  wdata;
    logic [31:0] bank;
    logic        busy;
    logic        tmo_err;

    int passed = 0;
    int total  = 0;
    logic [7:0] bank_m [4];

    spi_write_arbiter #(.Nbit(8), .RST_VAL(8'hFF), .TMO(15)) dut (
        .clk(clk), .rst(rst), .wr(wr), .din(din), .clr_err(clr_err),
        .wtreq(wtreq), .we(we), .wadr(wadr), .wdata(wdata),
        .bank(bank), .busy(busy), .tmo_err(tmo_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0] wr;
        logic [7:0] data;
        logic [1:0] exp_wadr;
        logic [3:0] exp_wtreq;
    } vec_t;

    vec_t tbl [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [31:0] bank_pack();
        return {bank_m[3], bank_m[2], bank_m[1], bank_m[0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) bank_m[i] = 8'hFF;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr = 4'h0;
        clr_err = 1'b0;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        tbl[0] = '{4'b0010, 8'hA5, 2'd1, 4'b1101};
        tbl[1] = '{4'b0001, 8'h5A, 2'd0, 4'b1110};
        tbl[2] = '{4'b1000, 8'hC3, 2'd3, 4'b0111};
        tbl[3] = '{4'b0100, 8'h96, 2'd2, 4'b1011};
        tbl[4] = '{4'b0010, 8'h11, 2'd1, 4'b1101};

        din = 32'h0102_0304;
        do_reset();
        chk("rst_we", {31'd0, we}, 0);
        chk("rst_wadr", {30'd0, wadr}, 0);
        chk("rst_wdata", {24'd0, wdata}, 0);
        chk("rst_wtreq", {28'd0, wtreq}, 32'hF);
        chk("rst_bank", bank, 32'hFFFF_FFFF);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_tmo", {31'd0, tmo_err}, 0);

        // Single-slave writes from the table
        for (int v = 0; v < 5; v++) begin
            int s;
            s = int'(tbl[v].exp_wadr);
            wr = tbl[v].wr;
            din[s*8 +: 8] = tbl[v].data;
            tick();
            bank_m[s] = tbl[v].data;
            chk("tbl_we", {31'd0, we}, 1);
            chk("tbl_wadr", {30'd0, wadr}, {30'd0, tbl[v].exp_wadr});
            chk("tbl_wdata", {24'd0, wdata}, {24'd0, tbl[v].data});
            chk("tbl_wtreq", {28'd0, wtreq}, {28'd0, tbl[v].exp_wtreq});
            chk("tbl_busy_w", {31'd0, busy}, 1);
            wr = 4'h0;
            din[s*8 +: 8] = ~tbl[v].data;
            din[((s+1)%4)*8 +: 8] = 8'h5C;
            tick();
            chk("tbl_we_rel", {31'd0, we}, 0);
            chk("tbl_wtreq_rel", {28'd0, wtreq}, 32'hF);
            chk("tbl_busy_r", {31'd0, busy}, 1);
            tick();
            chk("tbl_busy_i", {31'd0, busy}, 0);
            chk("tbl_wdata_hold", {24'd0, wdata}, {24'd0, tbl[v].data});
            chk("tbl_bank", bank, bank_pack());
        end

        // All four requesting after reset: order 0,1,2,3, every 3 cycles
        do_reset();
        din = 32'h4433_2211;
        wr = 4'hF;
        for (int k = 0; k < 4; k++) begin
            tick();
            bank_m[k] = 8'(8'h11 * (k + 1));
            chk("rr_we", {31'd0, we}, 1);
            chk("rr_wadr", {30'd0, wadr}, k);
            wr[k] = 1'b0;
            tick();
            chk("rr_we_gap1", {31'd0, we}, 0);
            tick();
            chk("rr_we_gap2", {31'd0, we}, 0);
        end
        chk("rr_bank", bank, bank_pack());

        // Slave 2 holds wr into a timeout; slave 3 pending meanwhile
        din[23:16] = 8'h2A;
        wr = 4'b0100;
        tick();
        bank_m[2] = 8'h2A;
        chk("to_wadr", {30'd0, wadr}, 2);
        wr = 4'b1100;
        for (int i = 0; i < 15; i++) tick();
        chk("to_tmo_before", {31'd0, tmo_err}, 0);
        chk("to_busy_before", {31'd0, busy}, 1);
        chk("to_wtreq_hold", {28'd0, wtreq}, 32'hF);
        tick();
        chk("to_tmo_set", {31'd0, tmo_err}, 1);
        chk("to_busy_idle", {31'd0, busy}, 0);
        din[23:16] = 8'h77;
        din[31:24] = 8'h3B;
        tick();
        bank_m[3] = 8'h3B;
        chk("to_next_wadr", {30'd0, wadr}, 3);
        chk("to_next_wtreq", {28'd0, wtreq}, 32'h7);
        wr = 4'b0100;
        tick();
        tick();
        tick();
        bank_m[2] = 8'h77;
        chk("to_regrant", {30'd0, wadr}, 2);
        wr = 4'b0000;
        tick();
        tick();
        chk("to_tmo_sticky", {31'd0, tmo_err}, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("to_clr", {31'd0, tmo_err}, 0);
        chk("to_bank", bank, bank_pack());

        // Slave 0 raises wr during slave 1's WRITE cycle
        din[15:8] = 8'h61;
        wr = 4'b0010;
        tick();
        bank_m[1] = 8'h61;
        chk("ho_wadr1", {30'd0, wadr}, 1);
        wr = 4'b0001;
        din[7:0] = 8'h60;
        tick();
        chk("ho_wtreq_rel", {28'd0, wtreq}, 32'hF);
        tick();
        chk("ho_idle", {31'd0, busy}, 0);
        chk("ho_wtreq_idle", {28'd0, wtreq}, 32'hF);
        tick();
        bank_m[0] = 8'h60;
        chk("ho_wadr0", {30'd0, wadr}, 0);
        chk("ho_we0", {31'd0, we}, 1);
        wr = 4'b0000;
        tick();
        tick();
        chk("ho_bank", bank, bank_pack());

        // Timeout and clr_err on the same edge: set wins
        din[15:8] = 8'h62;
        wr = 4'b0010;
        tick();
        bank_m[1] = 8'h62;
        chk("tc_wadr", {30'd0, wadr}, 1);
        for (int i = 0; i < 15; i++) tick();
        chk("tc_tmo_before", {31'd0, tmo_err}, 0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        wr = 4'b0000;
        chk("tc_tmo_wins", {31'd0, tmo_err}, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("tc_clr_after", {31'd0, tmo_err}, 0);

        // Reset asserted in slave 3's WRITE cycle
        din[31:24] = 8'h3C;
        wr = 4'b1000;
        tick();
        chk("ra_wadr", {30'd0, wadr}, 3);
        chk("ra_bank3_written", {24'd0, bank[31:24]}, 32'h3C);
        #2;
        rst = 1'b1;
        #1;
        chk("ra_bank3", {24'd0, bank[31:24]}, 32'hFF);
        chk("ra_we", {31'd0, we}, 0);
        chk("ra_wtreq", {28'd0, wtreq}, 32'hF);
        chk("ra_busy", {31'd0, busy}, 0);
        model_reset();
        wr = 4'b0000;
        tick();
        rst = 1'b0;
        tick();
        chk("ra_bank_all", bank, bank_pack());

        // First grant after reset goes to lowest requester
        din[15:8] = 8'h1E;
        wr = 4'b1010;
        tick();
        chk("pr_wadr", {30'd0, wadr}, 1);
        chk("pr_wdata", {24'd0, wdata}, 32'h1E);
        wr = 4'b1000;
        tick();
        tick();
        tick();
        chk("pr_next", {30'd0, wadr}, 3);
        wr = 4'b0000;
        tick();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
